morty_trap_ctrl: RTL and testbench
==================================

Name: morty_trap_ctrl

Overview:
- Trap/return sequencer for the writeback stage and its CSR file.
- Prioritises synchronous exceptions and the three machine interrupts (MEIP/MSIP/MTIP), then drains and flushes the pipeline.
- Performs the mepc/mcause/mstatus updates through a single CSR write port, one write per cycle, and issues the PC redirect.
- Handles mret the same way: mstatus update, then redirect to mepc.

Parameters:
- DRAIN_CYCLES, 3, cycles flush_o/stall_o are held before the CSR writes start (range 1..15).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- exc_valid_i  in  1  synchronous exception reported by WB.
- exc_code_i  in  4  exception cause code.
- exc_pc_i  in  32  PC of the faulting instruction.
- is_mret_i  in  1  mret retiring in WB.
- retire_valid_i  in  1  an instruction retires this cycle; interrupts are taken only at retirement.
- retire_npc_i  in  32  PC of the next instruction after the retiring one.
- int_meip_i, int_mtip_i, int_msip_i  in  1 each  level interrupt requests.
- mstatus_i  in  32  current mstatus.
- mie_i  in  32  current mie.
- mtvec_i  in  32  current mtvec.
- mepc_i  in  32  current mepc.
- flush_o  out  1  kill all younger instructions.
- stall_o  out  1  freeze IF..MEM.
- csr_we_o  out  1  CSR write strobe.
- csr_waddr_o  out  12  CSR write address.
- csr_wdata_o  out  32  CSR write data.
- redirect_valid_o  out  1  one-cycle PC redirect.
- redirect_pc_o  out  32  redirect target.
- busy_o  out  1  FSM not IDLE.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; every output 0; capture registers cleared. Reset mid-sequence aborts the sequence: no further CSR write or redirect is issued.
- Event selection (IDLE only, combinational from inputs in cycle T), highest priority first:
  - exc_valid_i.
  - Interrupt when mstatus_i[3] (MIE) && retire_valid_i, in order MEIP (mie_i[11], code 11), MSIP (mie_i[3], code 3), MTIP (mie_i[7], code 7).
  - is_mret_i.
  - Exception beats a simultaneous mret or interrupt. An enabled interrupt beats a simultaneous mret.
- Capture on the T edge:
  - Trap: is_int, cause, epc. epc = exc_pc_i for exceptions, retire_npc_i for interrupts.
  - mret: the mret flag only.
- States (Moore; all outputs decoded from registered state and capture regs): IDLE, DRAIN, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT.
- Trap sequence, starting at T+1:
  - DRAIN for DRAIN_CYCLES cycles, with flush_o=stall_o=1 (down-counter).
  - W_MEPC: we=1, addr=0x341, data={epc[31:2],2'b00}.
  - W_MCAUSE: we=1, addr=0x342, data={is_int,27'b0,cause}.
  - W_MSTATUS: we=1, addr=0x300, data=mstatus_i with MPIE[7]<=MIE[3], MIE[3]<=0, MPP[12:11]<=2'b11.
  - REDIRECT: redirect_valid_o=1 with redirect_pc_o as below, then back to IDLE.
  - Total latency from the event to redirect is DRAIN_CYCLES+4 cycles.
- Trap redirect target:
  - Vectored (mtvec_i[1:0]==2'b01) and is_int: {mtvec_i[31:2],2'b00} + 4*cause (32-bit wrap).
  - Otherwise: {mtvec_i[31:2],2'b00}.
- mret sequence: DRAIN (same length) -> W_MSTATUS -> REDIRECT -> IDLE.
  - W_MSTATUS: MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - REDIRECT: redirect_pc_o = {mepc_i[31:2],2'b00}.
- stall_o=1 in every non-IDLE state. flush_o=1 in DRAIN and REDIRECT.
- While busy_o=1, all new events are ignored and nothing is queued. Interrupts are level inputs and are re-evaluated in IDLE. Exceptions cannot occur because the pipeline is stalled.
- mstatus_i/mtvec_i/mepc_i are sampled in the state that uses them, so the values include the writes already made by the sequence.
- csr_we_o is never asserted in IDLE, DRAIN or REDIRECT. redirect_valid_o is asserted for exactly one cycle per sequence.

Decomposition:
- Shared header trap_defs.vh holds:
  - CSR addresses MSTATUS=0x300, MEPC=0x341, MCAUSE=0x342.
  - Interrupt cause codes 3/7/11.
  - mstatus bit positions.
  - State encodings (3-bit).
- One combinational sub-module morty_trap_prio: performs event selection and outputs take, is_int, cause[3:0], is_mret_sel.

Test Plan:
- Exception: exc_valid_i=1, exc_code_i=2, exc_pc_i=0x100, mtvec_i=0x200, mstatus_i=0x8.
  - flush_o for 3 cycles.
  - Writes 0x341<=0x100, then 0x342<=0x2, then 0x300<=0x1880.
  - redirect_pc_o=0x200 at T+7.
- Vectored interrupt: int_meip_i=1, mie_i[11]=1, MIE=1, retire_npc_i=0x44, mtvec_i=0x201.
  - mcause=0x8000000B, mepc=0x44, redirect_pc_o=0x22C.
- Masked/priority: MIE=0 with all interrupts pending -> busy_o stays 0.
  - Then MIE=1 with MSIP and MTIP both pending and enabled -> cause=3.
- Simultaneous: exc_valid_i and is_mret_i in the same cycle -> trap sequence, mcause=exc_code_i, no mret write.
- mret: mstatus_i=0x80, mepc_i=0x1236.
  - Single write 0x300<=0x1888.
  - redirect_pc_o=0x1234 at T+5.
- Reset: drop rst_i during W_MCAUSE.
  - All outputs 0 immediately (asynchronous).
  - After release: no redirect and no further writes.

Source files
------------

// File: rtl/morty_trap_ctrl_pkg.sv
// Shared definitions for the trap/return sequencer: CSR addresses, interrupt
// cause codes, mstatus bit positions, FSM states and mstatus update helpers.
package morty_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_W_MEPC    = 3'd2,
    ST_W_MCAUSE  = 3'd3,
    ST_W_MSTATUS = 3'd4,
    ST_REDIRECT  = 3'd5
  } state_t;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/morty_trap_prio.sv
// Event selection: exception, then enabled machine interrupts (MEI, MSI, MTI)
// taken only at retirement, then mret.
module morty_trap_prio
  import morty_trap_ctrl_pkg::*;
(
  input  logic       exc_valid_i,
  input  logic [3:0] exc_code_i,
  input  logic       is_mret_i,
  input  logic       retire_valid_i,
  input  logic       int_meip_i,
  input  logic       int_mtip_i,
  input  logic       int_msip_i,
  input  logic       mstatus_mie_i,
  input  logic       meie_i,
  input  logic       mtie_i,
  input  logic       msie_i,
  output logic       take_o,
  output logic       is_int_o,
  output logic [3:0] cause_o,
  output logic       is_mret_sel_o
);

  logic int_ok;

  assign int_ok = mstatus_mie_i && retire_valid_i;

  always_comb begin
    take_o        = 1'b0;
    is_int_o      = 1'b0;
    cause_o       = exc_code_i;
    is_mret_sel_o = 1'b0;
    if (exc_valid_i) begin
      take_o = 1'b1;
    end else if (int_ok && int_meip_i && meie_i) begin
      take_o   = 1'b1;
      is_int_o = 1'b1;
      cause_o  = CAUSE_MEI;
    end else if (int_ok && int_msip_i && msie_i) begin
      take_o   = 1'b1;
      is_int_o = 1'b1;
      cause_o  = CAUSE_MSI;
    end else if (int_ok && int_mtip_i && mtie_i) begin
      take_o   = 1'b1;
      is_int_o = 1'b1;
      cause_o  = CAUSE_MTI;
    end else if (is_mret_i) begin
      take_o        = 1'b1;
      is_mret_sel_o = 1'b1;
    end
  end

endmodule

// File: rtl/morty_trap_ctrl.sv
// Trap/mret sequencer: drains the pipeline, writes mepc/mcause/mstatus through
// one CSR port (one write per cycle), then issues a one-cycle PC redirect.
module morty_trap_ctrl
  import morty_trap_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        is_mret_i,
  input  logic        retire_valid_i,
  input  logic [31:0] retire_npc_i,
  input  logic        int_meip_i,
  input  logic        int_mtip_i,
  input  logic        int_msip_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        flush_o,
  output logic        stall_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        is_int_q, mret_q;
  logic [3:0]  cause_q;
  logic [31:2] epc_q;

  logic        sel_take, sel_is_int, sel_mret;
  logic [3:0]  sel_cause;
  logic [31:0] mtvec_base, trap_target;
  logic        unused_bits;

  assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                         mepc_i[1:0], exc_pc_i[1:0], retire_npc_i[1:0]};

  morty_trap_prio u_prio (
    .exc_valid_i   (exc_valid_i),
    .exc_code_i    (exc_code_i),
    .is_mret_i     (is_mret_i),
    .retire_valid_i(retire_valid_i),
    .int_meip_i    (int_meip_i),
    .int_mtip_i    (int_mtip_i),
    .int_msip_i    (int_msip_i),
    .mstatus_mie_i (mstatus_i[MSTATUS_MIE]),
    .meie_i        (mie_i[CAUSE_MEI]),
    .mtie_i        (mie_i[CAUSE_MTI]),
    .msie_i        (mie_i[CAUSE_MSI]),
    .take_o        (sel_take),
    .is_int_o      (sel_is_int),
    .cause_o       (sel_cause),
    .is_mret_sel_o (sel_mret)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      is_int_q <= 1'b0;
      mret_q   <= 1'b0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == ST_IDLE && sel_take) begin
        mret_q <= sel_mret;
        if (!sel_mret) begin
          is_int_q <= sel_is_int;
          cause_q  <= sel_cause;
          epc_q    <= sel_is_int ? retire_npc_i[31:2] : exc_pc_i[31:2];
        end
      end
    end
  end

  // Vectored mode offsets only interrupts; exceptions always land on the base.
  assign mtvec_base  = {mtvec_i[31:2], 2'b00};
  assign trap_target = (mtvec_i[1:0] == 2'b01 && is_int_q)
                       ? mtvec_base + {26'b0, cause_q, 2'b00}
                       : mtvec_base;

  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    busy_o           = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (sel_take) begin
          state_n = ST_DRAIN;
          cnt_n   = CNT_INIT;
        end
      end
      ST_DRAIN: begin
        flush_o = 1'b1;
        stall_o = 1'b1;
        if (cnt == '0) state_n = mret_q ? ST_W_MSTATUS : ST_W_MEPC;
        else           cnt_n   = cnt - 4'd1;
      end
      ST_W_MEPC: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = {epc_q, 2'b00};
        state_n     = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = {is_int_q, 27'b0, cause_q};
        state_n     = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mret_q ? mret_mstatus(mstatus_i) : trap_mstatus(mstatus_i);
        state_n     = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        flush_o          = 1'b1;
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mret_q ? {mepc_i[31:2], 2'b00} : trap_target;
        state_n          = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_morty_trap_ctrl.sv
// Scoreboard bench for morty_trap_ctrl: stimulus pushes expected CSR writes and
// redirects (with their cycle), a monitor pops and compares each DUT event.
module tb_morty_trap_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        exc_valid_i;
  logic [3:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        is_mret_i;
  logic        retire_valid_i;
  logic [31:0] retire_npc_i;
  logic        int_meip_i, int_mtip_i, int_msip_i;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        flush_o, stall_o, csr_we_o, redirect_valid_o, busy_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, redirect_pc_o;

  typedef struct {
    bit          redir;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  morty_trap_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .exc_valid_i     (exc_valid_i),
    .exc_code_i      (exc_code_i),
    .exc_pc_i        (exc_pc_i),
    .is_mret_i       (is_mret_i),
    .retire_valid_i  (retire_valid_i),
    .retire_npc_i    (retire_npc_i),
    .int_meip_i      (int_meip_i),
    .int_mtip_i      (int_mtip_i),
    .int_msip_i      (int_msip_i),
    .mstatus_i       (mstatus_i),
    .mie_i           (mie_i),
    .mtvec_i         (mtvec_i),
    .mepc_i          (mepc_i),
    .flush_o         (flush_o),
    .stall_o         (stall_o),
    .csr_we_o        (csr_we_o),
    .csr_waddr_o     (csr_waddr_o),
    .csr_wdata_o     (csr_wdata_o),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o   (redirect_pc_o),
    .busy_o          (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic push_w(input logic [11:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.redir = 1'b0; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] pc, input int c);
    exp_t e;
    e.redir = 1'b1; e.addr = '0; e.data = pc; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic clear_events();
    exc_valid_i = 1'b0; is_mret_i = 1'b0; retire_valid_i = 1'b0;
    int_meip_i = 1'b0; int_mtip_i = 1'b0; int_msip_i = 1'b0;
  endtask

  // Event inputs are already set; let the T edge capture them, then drop them.
  task automatic fire();
    @(posedge clk_i);
    #1 clear_events();
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !busy_o) break;
    end
    check(name, {31'b0, (exp_q.size() == 0 && !busy_o)}, 32'd1);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t        e;
        logic [11:0] aa;
        logic [31:0] dd;
        forever begin
          @(negedge clk_i);
          if (csr_we_o || redirect_valid_o) begin
            aa = redirect_valid_o ? 12'h000 : csr_waddr_o;
            dd = redirect_valid_o ? redirect_pc_o : csr_wdata_o;
            n_assert++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_event: actual redir=%0b addr=0x%03h data=0x%08h cyc=%0d, required no event",
                       redirect_valid_o, aa, dd, cyc);
            end else begin
              e = exp_q.pop_front();
              if (redirect_valid_o !== e.redir || aa !== e.addr || dd !== e.data || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL scoreboard: actual redir=%0b addr=0x%03h data=0x%08h cyc=%0d, required redir=%0b addr=0x%03h data=0x%08h cyc=%0d",
                         redirect_valid_o, aa, dd, cyc, e.redir, e.addr, e.data, e.cyc);
              end
            end
          end
        end
      end
      begin : stimulus
        int c;
        int nfl;
        logic busy_hi;
        rst_i = 1'b0;
        clear_events();
        exc_code_i = '0; exc_pc_i = '0; retire_npc_i = '0;
        mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;
        repeat (2) @(negedge clk_i);
        check("reset_ctrl", {27'b0, flush_o, stall_o, csr_we_o, redirect_valid_o, busy_o}, 32'd0);
        check("reset_waddr", {20'b0, csr_waddr_o}, 32'd0);
        check("reset_wdata", csr_wdata_o, 32'd0);
        check("reset_rpc", redirect_pc_o, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Exception, direct mode; a late exception pulse while busy is ignored
        mtvec_i = 32'h200; mstatus_i = 32'h8;
        exc_code_i = 4'd2; exc_pc_i = 32'h100; exc_valid_i = 1'b1;
        c = cyc;
        push_w(12'h341, 32'h100, c + 4);
        push_w(12'h342, 32'h2, c + 5);
        push_w(12'h300, 32'h1880, c + 6);
        push_r(32'h200, c + 7);
        fire();
        nfl = 0;
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk_i);
          nfl += int'(flush_o);
          if (i == 2) begin
            exc_valid_i = 1'b1; exc_code_i = 4'd9; exc_pc_i = 32'h999;
          end else begin
            exc_valid_i = 1'b0;
          end
        end
        check("exc_flush_cycles", nfl, 32'd3);
        wait_idle("exc_done");

        // Vectored MEI
        mstatus_i = 32'h8; mie_i = 32'h800; int_meip_i = 1'b1;
        retire_valid_i = 1'b1; retire_npc_i = 32'h44; mtvec_i = 32'h201;
        c = cyc;
        push_w(12'h341, 32'h44, c + 4);
        push_w(12'h342, 32'h8000000B, c + 5);
        push_w(12'h300, 32'h1880, c + 6);
        push_r(32'h22C, c + 7);
        fire();
        wait_idle("mei_done");

        // Global MIE clear masks everything
        mstatus_i = 32'h0; mie_i = 32'h888; retire_valid_i = 1'b1;
        int_meip_i = 1'b1; int_msip_i = 1'b1; int_mtip_i = 1'b1;
        busy_hi = 1'b0;
        repeat (5) begin
          @(negedge clk_i);
          busy_hi |= busy_o;
        end
        check("masked_busy", {31'b0, busy_hi}, 32'd0);

        // MSI wins over MTI
        mstatus_i = 32'h8; int_meip_i = 1'b0; retire_npc_i = 32'h80; mtvec_i = 32'h201;
        c = cyc;
        push_w(12'h341, 32'h80, c + 4);
        push_w(12'h342, 32'h80000003, c + 5);
        push_w(12'h300, 32'h1880, c + 6);
        push_r(32'h20C, c + 7);
        fire();
        wait_idle("msi_done");

        // Enabled MTI beats simultaneous mret
        mstatus_i = 32'h8; mie_i = 32'h80; int_mtip_i = 1'b1; retire_valid_i = 1'b1;
        is_mret_i = 1'b1; retire_npc_i = 32'h10; mtvec_i = 32'h100; mepc_i = 32'h5000;
        c = cyc;
        push_w(12'h341, 32'h10, c + 4);
        push_w(12'h342, 32'h80000007, c + 5);
        push_w(12'h300, 32'h1880, c + 6);
        push_r(32'h100, c + 7);
        fire();
        wait_idle("mti_mret_done");

        // Exception beats simultaneous mret; vectored mtvec ignored for exceptions
        mstatus_i = 32'h8; exc_valid_i = 1'b1; exc_code_i = 4'd5; exc_pc_i = 32'h2002;
        is_mret_i = 1'b1; mtvec_i = 32'h201; mepc_i = 32'h5000;
        c = cyc;
        push_w(12'h341, 32'h2000, c + 4);
        push_w(12'h342, 32'h5, c + 5);
        push_w(12'h300, 32'h1880, c + 6);
        push_r(32'h200, c + 7);
        fire();
        wait_idle("exc_mret_done");

        // mret
        mstatus_i = 32'h80; mepc_i = 32'h1236; mtvec_i = 32'h200; is_mret_i = 1'b1;
        c = cyc;
        push_w(12'h300, 32'h1888, c + 4);
        push_r(32'h1234, c + 5);
        fire();
        wait_idle("mret_done");

        // Asynchronous reset during W_MCAUSE aborts the sequence
        mstatus_i = 32'h8; exc_valid_i = 1'b1; exc_code_i = 4'd1; exc_pc_i = 32'h300;
        mtvec_i = 32'h400;
        c = cyc;
        push_w(12'h341, 32'h300, c + 4);
        push_w(12'h342, 32'h1, c + 5);
        fire();
        for (int k = 0; k < 20 && cyc < c + 5; k++) @(negedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        check("arst_ctrl", {27'b0, flush_o, stall_o, csr_we_o, redirect_valid_o, busy_o}, 32'd0);
        check("arst_waddr", {20'b0, csr_waddr_o}, 32'd0);
        check("arst_wdata", csr_wdata_o, 32'd0);
        check("arst_queue", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        busy_hi = 1'b0;
        repeat (15) begin
          @(negedge clk_i);
          busy_hi |= busy_o;
        end
        check("post_reset_busy", {31'b0, busy_hi}, 32'd0);
      end
      begin : watchdog
        #200000;
        n_assert++;
        n_fail++;
        $display("FAIL watchdog: actual timeout, required stimulus completion");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
